mem_port_arbiter: RTL and testbench

- Shares one single-port unified instruction/data memory between two requesters: the instruction-fetch stage (IF, read only) and the load/store unit (LS, read/write).
- Sits between the RISCV core's fetch/LSU and the memory model.
- Serialises accesses with a per-requester req/done handshake and a memory-side req/ready handshake.
- LS has priority, with bounded IF starvation.

---
 rtl/riscv_mem_pkg.sv | 21 ++
 rtl/mem_arb_perf.sv | 34 +++
 rtl/mem_port_arbiter.sv | 166 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 518 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the unified instruction/data memory port arbiter.
// Contents: arbiter FSM state encoding, bus-owner encoding, and default
// address/data widths used by the fetch/LSU memory path.
package riscv_mem_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_BUSY_IF = 2'd1,
    ARB_BUSY_LS = 2'd2,
    ARB_RESP    = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } arb_owner_t;

endpackage

// File: rtl/mem_arb_perf.sv
// Performance counters for mem_port_arbiter (present only when the top is
// built with MEM_ARB_PERF_CNT_EN defined).
// Ports:
//   clk, reset         - clock, synchronous active-high reset
//   if_complete        - IF access entering its response cycle this edge
//   ls_complete        - LS access entering its response cycle this edge
//   conflict           - IDLE cycle with both requests asserted
//   perf_if_cnt        - completed IF accesses (wraps mod 2^32)
//   perf_ls_cnt        - completed LS accesses (wraps mod 2^32)
//   perf_conflict_cnt  - contended IDLE cycles (wraps mod 2^32)
module mem_arb_perf (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_complete,
  input  logic        ls_complete,
  input  logic        conflict,
  output logic [31:0] perf_if_cnt,
  output logic [31:0] perf_ls_cnt,
  output logic [31:0] perf_conflict_cnt
);

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_if_cnt       <= '0;
      perf_ls_cnt       <= '0;
      perf_conflict_cnt <= '0;
    end else begin
      if (if_complete) perf_if_cnt       <= perf_if_cnt + 32'd1;
      if (ls_complete) perf_ls_cnt       <= perf_ls_cnt + 32'd1;
      if (conflict)    perf_conflict_cnt <= perf_conflict_cnt + 32'd1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port unified memory between the instruction
// fetch stage (IF, read only) and the load/store unit (LS, read/write).
// LS has priority; IF may lose at most STARVE_MAX consecutive contended
// arbitrations. Every access occupies IDLE -> BUSY_x -> RESP (>= 3 cycles).
// Optional build macro: MEM_ARB_PERF_CNT_EN adds perf_if_cnt, perf_ls_cnt
// and perf_conflict_cnt outputs (32-bit, wrapping).
// Ports:
//   clk, reset                 - clock, synchronous active-high reset
//   if_req/if_addr             - IF read request, held until if_done
//   if_done/if_rdata           - IF one-cycle completion pulse, fetched word
//   ls_req/ls_we/ls_addr/
//   ls_wdata/ls_wstrb          - LS request, held until ls_done
//   ls_done/ls_rdata           - LS completion pulse, load data
//   mem_req/mem_we/mem_addr/
//   mem_wdata/mem_wstrb        - memory request, held until mem_ready
//   mem_ready/mem_rdata        - memory completion and read data
module mem_port_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_done,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                ls_req,
  input  logic                ls_we,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic [DATA_W-1:0]   ls_wdata,
  input  logic [DATA_W/8-1:0] ls_wstrb,
  output logic                ls_done,
  output logic [DATA_W-1:0]   ls_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic                mem_ready,
  input  logic [DATA_W-1:0]   mem_rdata
`ifdef MEM_ARB_PERF_CNT_EN
  ,
  output logic [31:0]         perf_if_cnt,
  output logic [31:0]         perf_ls_cnt,
  output logic [31:0]         perf_conflict_cnt
`endif
);

  localparam int unsigned STARVE_W = $clog2(STARVE_MAX + 1);
  localparam logic [STARVE_W-1:0] STARVE_TOP = STARVE_W'(STARVE_MAX);

  arb_state_t          state, state_nxt;
  arb_owner_t          win_owner;
  logic                win_valid;
  logic                mem_done;
  logic                idle_contended;
  logic [STARVE_W-1:0] starve_cnt;

  always_comb begin
    state_nxt      = state;
    win_valid      = 1'b0;
    win_owner      = OWN_LS;
    mem_done       = 1'b0;
    idle_contended = 1'b0;
    case (state)
      ARB_IDLE: begin
        idle_contended = if_req && ls_req;
        // LS wins unless IF is contending and has already lost STARVE_MAX times
        if (ls_req && !(if_req && (starve_cnt == STARVE_TOP))) begin
          win_valid = 1'b1;
          win_owner = OWN_LS;
          state_nxt = ARB_BUSY_LS;
        end else if (if_req) begin
          win_valid = 1'b1;
          win_owner = OWN_IF;
          state_nxt = ARB_BUSY_IF;
        end
      end
      ARB_BUSY_IF, ARB_BUSY_LS: begin
        if (mem_ready) begin
          mem_done  = 1'b1;
          state_nxt = ARB_RESP;
        end
      end
      ARB_RESP: state_nxt = ARB_IDLE;
      default:  state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ARB_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (win_valid) begin
      if (win_owner == OWN_IF)
        starve_cnt <= '0;
      else if (idle_contended && (starve_cnt != STARVE_TOP))
        starve_cnt <= starve_cnt + STARVE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      if_done   <= 1'b0;
      if_rdata  <= '0;
      ls_done   <= 1'b0;
      ls_rdata  <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
    end else begin
      if_done <= 1'b0;
      ls_done <= 1'b0;
      if (win_valid) begin
        mem_req <= 1'b1;
        if (win_owner == OWN_LS) begin
          mem_we    <= ls_we;
          mem_addr  <= ls_addr;
          mem_wdata <= ls_wdata;
          // loads never carry strobes onto the memory bus
          mem_wstrb <= ls_we ? ls_wstrb : '0;
        end else begin
          mem_we    <= 1'b0;
          mem_addr  <= if_addr;
          mem_wdata <= '0;
          mem_wstrb <= '0;
        end
      end
      if (mem_done) begin
        mem_req   <= 1'b0;
        mem_we    <= 1'b0;
        mem_wstrb <= '0;
        if (state == ARB_BUSY_IF) begin
          if_rdata <= mem_rdata;
          if_done  <= 1'b1;
        end else begin
          if (!mem_we) ls_rdata <= mem_rdata;
          ls_done <= 1'b1;
        end
      end
    end
  end

`ifdef MEM_ARB_PERF_CNT_EN
  mem_arb_perf u_perf (
    .clk               (clk),
    .reset             (reset),
    .if_complete       (mem_done && (state == ARB_BUSY_IF)),
    .ls_complete       (mem_done && (state == ARB_BUSY_LS)),
    .conflict          (idle_contended),
    .perf_if_cnt       (perf_if_cnt),
    .perf_ls_cnt       (perf_ls_cnt),
    .perf_conflict_cnt (perf_conflict_cnt)
  );
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed cycle-level scenarios
// plus randomized IF/LS traffic checked against a behavioural memory model
// and the bounded-starvation rule.
module tb_mem_port_arbiter;

  localparam int unsigned SMAX = 4;

  logic        clk;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_rdata;
  logic        ls_req;
  logic        ls_we;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic [3:0]  ls_wstrb;
  logic        ls_done;
  logic [31:0] ls_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
`ifdef MEM_ARB_PERF_CNT_EN
  logic [31:0] perf_if_cnt;
  logic [31:0] perf_ls_cnt;
  logic [31:0] perf_conflict_cnt;
`endif

  mem_port_arbiter #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .STARVE_MAX (SMAX)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_done   (if_done),
    .if_rdata  (if_rdata),
    .ls_req    (ls_req),
    .ls_we     (ls_we),
    .ls_addr   (ls_addr),
    .ls_wdata  (ls_wdata),
    .ls_wstrb  (ls_wstrb),
    .ls_done   (ls_done),
    .ls_rdata  (ls_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata)
`ifdef MEM_ARB_PERF_CNT_EN
    ,
    .perf_if_cnt       (perf_if_cnt),
    .perf_ls_cnt       (perf_ls_cnt),
    .perf_conflict_cnt (perf_conflict_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  // behavioural memory: sparse words, deterministic default content
  logic [31:0] mem_model [logic [31:0]];
  bit          mem_auto = 1'b0;
  bit          mem_rand = 1'b0;
  int          mem_wait = 0;
  int          ls_done_total = 0;
  logic [31:0] exp_if_rdata = '0;
  logic [31:0] exp_ls_rdata = '0;

  function automatic logic [31:0] mem_peek(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return (a * 32'h0001_0003) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_w,
                                        input logic [31:0] new_w,
                                        input logic [3:0]  strb);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++)
      if (strb[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  // memory responder: answers after a fixed or random number of wait cycles
  initial begin
    int cnt;
    int cur_wait;
    bit busy;
    mem_ready = 1'b0;
    mem_rdata = '0;
    cnt = 0;
    cur_wait = 0;
    busy = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_auto) begin
        mem_ready = 1'b0;
        if (mem_req === 1'b1) begin
          if (!busy) begin
            busy = 1'b1;
            cnt = 0;
            cur_wait = mem_rand ? int'($urandom_range(3, 0)) : mem_wait;
          end
          if (cnt == cur_wait) begin
            if (mem_we === 1'b1)
              mem_model[mem_addr] = merge(mem_peek(mem_addr), mem_wdata, mem_wstrb);
            else
              mem_rdata = mem_peek(mem_addr);
            mem_ready = 1'b1;
            busy = 1'b0;
          end else begin
            cnt++;
          end
        end else begin
          busy = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) if (ls_done === 1'b1) ls_done_total++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  task automatic clear_inputs;
    if_req = 1'b0; if_addr = '0;
    ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0; ls_wstrb = '0;
  endtask

  task automatic test_reset;
    clear_inputs();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({if_done, ls_done, mem_req, mem_we} !== 4'b0000) begin
      bad++; $display("FAIL reset_ctrl: got %b want 0000", {if_done, ls_done, mem_req, mem_we});
    end
    total++;
    if ({if_rdata, ls_rdata} !== 64'd0) begin
      bad++; $display("FAIL reset_rdata: got %h %h want 0", if_rdata, ls_rdata);
    end
    total++;
    if ({mem_addr, mem_wdata, mem_wstrb} !== 68'd0) begin
      bad++; $display("FAIL reset_mem: got %h %h %h want 0", mem_addr, mem_wdata, mem_wstrb);
    end
    reset = 1'b0;
    exp_if_rdata = '0;
    exp_ls_rdata = '0;
    @(negedge clk);
  endtask

  task automatic test_if_read;
    mem_model[32'h10] = 32'h00500093;
    mem_auto = 1'b1; mem_wait = 0; mem_rand = 1'b0;
    if_req = 1'b1; if_addr = 32'h10;
    @(negedge clk);
    total++;
    if ({mem_req, mem_we, mem_wstrb, mem_addr, if_done} !== {1'b1, 1'b0, 4'b0, 32'h10, 1'b0}) begin
      bad++; $display("FAIL if_read_c1: req=%b we=%b strb=%b addr=%h done=%b want 1 0 0 00000010 0",
                      mem_req, mem_we, mem_wstrb, mem_addr, if_done);
    end
    @(negedge clk);
    total++;
    if ({if_done, mem_req} !== 2'b10) begin
      bad++; $display("FAIL if_read_c2: done=%b mem_req=%b want 1 0", if_done, mem_req);
    end
    total++;
    if (if_rdata !== 32'h00500093) begin
      bad++; $display("FAIL if_read_data: got %h want 00500093", if_rdata);
    end
    if_req = 1'b0;
    exp_if_rdata = 32'h00500093;
    @(negedge clk);
    total++;
    if ({if_done, if_rdata} !== {1'b0, 32'h00500093}) begin
      bad++; $display("FAIL if_read_hold: done=%b rdata=%h want 0 00500093", if_done, if_rdata);
    end
  endtask

  task automatic test_ls_store_wait;
    int  n_high;
    bit  stable_ok;
    mem_model[32'h100] = 32'h11223344;
    mem_wait = 3;
    n_high = 0;
    stable_ok = 1'b1;
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h100; ls_wdata = 32'hDEADBEEF; ls_wstrb = 4'b0011;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_req !== 1'b1) break;
      n_high++;
      if ({mem_we, mem_addr, mem_wdata, mem_wstrb} !== {1'b1, 32'h100, 32'hDEADBEEF, 4'b0011})
        stable_ok = 1'b0;
    end
    total++;
    if (n_high != 4) begin
      bad++; $display("FAIL store_req_len: got %0d cycles want 4", n_high);
    end
    total++;
    if (!stable_ok) begin
      bad++; $display("FAIL store_stable: got unstable mem fields want stable");
    end
    total++;
    if ({ls_done, mem_we, mem_wstrb} !== {1'b1, 1'b0, 4'b0}) begin
      bad++; $display("FAIL store_done: done=%b we=%b strb=%b want 1 0 0000", ls_done, mem_we, mem_wstrb);
    end
    total++;
    if (ls_rdata !== exp_ls_rdata) begin
      bad++; $display("FAIL store_rdata: got %h want %h", ls_rdata, exp_ls_rdata);
    end
    total++;
    if (mem_peek(32'h100) !== 32'h1122BEEF) begin
      bad++; $display("FAIL store_mem: got %h want 1122beef", mem_peek(32'h100));
    end
    ls_req = 1'b0; ls_we = 1'b0;
    @(negedge clk);
    total++;
    if (ls_done !== 1'b0) begin
      bad++; $display("FAIL store_pulse: ls_done=%b want 0", ls_done);
    end
    mem_wait = 0;
  endtask

  task automatic test_contention;
    int   grants;
    int   losses;
    logic prev;
    bit   exp_ls;
    bit   act_ls;
    mem_wait = 0;
    grants = 0; losses = 0; prev = 1'b0;
    if_addr = 32'h200; ls_addr = 32'h300; ls_we = 1'b0;
    if_req = 1'b1; ls_req = 1'b1;
    for (int c = 0; c < 200 && grants < 10; c++) begin
      @(negedge clk);
      if (mem_req === 1'b1 && prev === 1'b0) begin
        exp_ls = (losses != SMAX);
        losses = exp_ls ? losses + 1 : 0;
        act_ls = (mem_addr === 32'h300);
        total++;
        if (act_ls != exp_ls || (!act_ls && mem_addr !== 32'h200)) begin
          bad++; $display("FAIL grant_order[%0d]: got addr %h want %s", grants, mem_addr, exp_ls ? "LS" : "IF");
        end
        grants++;
      end
      prev = mem_req;
    end
    total++;
    if (grants != 10) begin
      bad++; $display("FAIL grant_timeout: got %0d grants want 10", grants);
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (if_done === 1'b1) break;
    end
    total++;
    if ({if_done, if_rdata} !== {1'b1, mem_peek(32'h200)}) begin
      bad++; $display("FAIL contention_if_data: done=%b rdata=%h want 1 %h", if_done, if_rdata, mem_peek(32'h200));
    end
    if_req = 1'b0; ls_req = 1'b0;
    exp_if_rdata = mem_peek(32'h200);
    exp_ls_rdata = mem_peek(32'h300);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_stale_ready;
    bit quiet;
    quiet = 1'b1;
    mem_auto = 1'b0;
    mem_ready = 1'b1; mem_rdata = 32'hBAD0BAD0;
    @(negedge clk);
    mem_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if ({if_done, ls_done, mem_req} !== 3'b000) quiet = 1'b0;
    end
    total++;
    if (!quiet) begin
      bad++; $display("FAIL stale_ready_ctrl: got activity want none");
    end
    total++;
    if ({if_rdata, ls_rdata} !== {exp_if_rdata, exp_ls_rdata}) begin
      bad++; $display("FAIL stale_ready_data: got %h %h want %h %h", if_rdata, ls_rdata, exp_if_rdata, exp_ls_rdata);
    end
    mem_auto = 1'b1;
  endtask

  task automatic test_back_to_back;
    int gap;
    bit seen;
    mem_wait = 0;
    if_addr = 32'h40; if_req = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (if_done === 1'b1) begin seen = 1'b1; break; end
    end
    gap = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (mem_req === 1'b1) begin gap = k; break; end
    end
    total++;
    if (!seen || gap != 2) begin
      bad++; $display("FAIL b2b_gap: got %0d (first done seen=%0d) want 2", gap, seen);
    end
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (if_done === 1'b1) begin seen = 1'b1; break; end
    end
    total++;
    if (!seen || if_rdata !== mem_peek(32'h40)) begin
      bad++; $display("FAIL b2b_data: got %h (done seen=%0d) want %h", if_rdata, seen, mem_peek(32'h40));
    end
    if_req = 1'b0;
    exp_if_rdata = mem_peek(32'h40);
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    bit quiet;
    bit seen;
    mem_auto = 1'b0;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h500;
    @(negedge clk);
    total++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h500}) begin
      bad++; $display("FAIL rst_mid_busy: req=%b addr=%h want 1 00000500", mem_req, mem_addr);
    end
    @(negedge clk);
    reset = 1'b1; ls_req = 1'b0;
    @(negedge clk);
    total++;
    if ({if_done, ls_done, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, if_rdata, ls_rdata} !== '0) begin
      bad++; $display("FAIL rst_mid_zero: req=%b addr=%h ifd=%h lsd=%h want all 0", mem_req, mem_addr, if_rdata, ls_rdata);
    end
    reset = 1'b0;
    exp_if_rdata = '0; exp_ls_rdata = '0;
    @(negedge clk);
    mem_ready = 1'b1; mem_rdata = 32'hCAFEF00D;
    @(negedge clk);
    mem_ready = 1'b0;
    quiet = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if ({if_done, ls_done, mem_req} !== 3'b000 || ls_rdata !== 32'd0) quiet = 1'b0;
    end
    total++;
    if (!quiet) begin
      bad++; $display("FAIL rst_mid_late_ready: got activity or ls_rdata=%h want none", ls_rdata);
    end
    mem_auto = 1'b1; mem_wait = 0;
    if_addr = 32'h10; if_req = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (if_done === 1'b1) begin seen = 1'b1; break; end
    end
    total++;
    if (!seen || if_rdata !== 32'h00500093) begin
      bad++; $display("FAIL rst_mid_recover: got %h (done seen=%0d) want 00500093", if_rdata, seen);
    end
    if_req = 1'b0;
    exp_if_rdata = 32'h00500093;
    @(negedge clk);
  endtask

  task automatic if_traffic;
    int          snap;
    bit          got;
    logic [31:0] a;
    for (int n = 0; n < 25; n++) begin
      repeat ($urandom_range(3, 0)) @(negedge clk);
      a = 32'($urandom_range(15, 0)) << 2;
      if_addr = a; if_req = 1'b1;
      snap = ls_done_total;
      got = 1'b0;
      for (int c = 0; c < 200; c++) begin
        @(negedge clk);
        if (if_done === 1'b1) begin got = 1'b1; break; end
      end
      total++;
      if (!got) begin
        bad++; $display("FAIL rnd_if_timeout: txn %0d addr %h no done", n, a);
      end else if (if_rdata !== mem_peek(a)) begin
        bad++; $display("FAIL rnd_if_data: addr %h got %h want %h", a, if_rdata, mem_peek(a));
      end
      total++;
      if (ls_done_total - snap > int'(SMAX) + 1) begin
        bad++; $display("FAIL rnd_starve: got %0d LS completions while IF waited want <= %0d",
                        ls_done_total - snap, SMAX + 1);
      end
      if_req = 1'b0;
    end
  endtask

  task automatic ls_traffic;
    bit          got;
    bit          we;
    logic [31:0] a, wd, exp_w;
    logic [3:0]  st;
    for (int n = 0; n < 25; n++) begin
      repeat ($urandom_range(2, 0)) @(negedge clk);
      a  = 32'($urandom_range(15, 0)) << 2;
      we = 1'($urandom_range(1, 0));
      wd = $urandom;
      st = 4'($urandom_range(15, 0));
      exp_w = merge(mem_peek(a), wd, st);
      ls_addr = a; ls_we = we; ls_wdata = wd; ls_wstrb = st; ls_req = 1'b1;
      got = 1'b0;
      for (int c = 0; c < 200; c++) begin
        @(negedge clk);
        if (ls_done === 1'b1) begin got = 1'b1; break; end
      end
      total++;
      if (!got) begin
        bad++; $display("FAIL rnd_ls_timeout: txn %0d addr %h no done", n, a);
      end else if (we) begin
        if (mem_peek(a) !== exp_w || ls_rdata !== exp_ls_rdata) begin
          bad++; $display("FAIL rnd_ls_store: addr %h mem %h rdata %h want mem %h rdata %h",
                          a, mem_peek(a), ls_rdata, exp_w, exp_ls_rdata);
        end
      end else begin
        if (ls_rdata !== mem_peek(a)) begin
          bad++; $display("FAIL rnd_ls_load: addr %h got %h want %h", a, ls_rdata, mem_peek(a));
        end
        exp_ls_rdata = mem_peek(a);
      end
      ls_req = 1'b0;
    end
  endtask

  task automatic test_random;
    mem_rand = 1'b1;
    fork
      if_traffic();
      ls_traffic();
    join
    mem_rand = 1'b0;
    repeat (3) @(negedge clk);
  endtask

`ifdef MEM_ARB_PERF_CNT_EN
  task automatic test_perf;
    clear_inputs();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    mem_wait = 0;
    if_addr = 32'h8; ls_addr = 32'hC; ls_we = 1'b0;
    for (int r = 0; r < 2; r++) begin
      if_req = 1'b1; ls_req = 1'b1;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (ls_done === 1'b1) break;
      end
      ls_req = 1'b0;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (if_done === 1'b1) break;
      end
      if_req = 1'b0;
    end
    if_req = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (if_done === 1'b1) break;
    end
    if_req = 1'b0;
    @(negedge clk);
    total++;
    if ({perf_if_cnt, perf_ls_cnt, perf_conflict_cnt} !== {32'd3, 32'd2, 32'd2}) begin
      bad++; $display("FAIL perf_counts: got if=%0d ls=%0d conf=%0d want 3 2 2",
                      perf_if_cnt, perf_ls_cnt, perf_conflict_cnt);
    end
  endtask
`endif

  initial begin
    clear_inputs();
    reset = 1'b1;
    test_reset();
    test_if_read();
    test_ls_store_wait();
    test_contention();
    test_stale_ready();
    test_back_to_back();
    test_reset_mid();
    test_random();
`ifdef MEM_ARB_PERF_CNT_EN
    test_perf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
